// File: rtl/fim_rdack_scfifo.sv
// Purpose : single-clock show-ahead FIFO; head entry is presented on rdata while rvalid=1, rdack pops it.
// Latency : a word written into an empty FIFO is visible on rdata the cycle after the write edge; 1 word/cycle streaming.
// Backpres: wreq is ignored while wfull=1; almfull gives the producer ALMOST_FULL_THRESHOLD skid slots of warning.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset (empties the FIFO immediately)
//   wdata, wreq       write data and write request (accepted when wfull=0)
//   rdack             read acknowledge (pops the head entry when rvalid=1)
//   rdata, rvalid     head entry and its valid flag
//   wusedw, rusedw    occupancy count, 0..2^DEPTH_LOG2 (both views carry the same value)
//   wfull, rfull      full flag (both views)
//   wempty, rempty    empty flag (both views)
//   almfull           occupancy >= 2^DEPTH_LOG2 - ALMOST_FULL_THRESHOLD
//
// The write-side/read-side duplicate status ports mirror the dual-clock FIFO so callers can
// swap between the two implementations without rewiring. READ_ACLR_SYNC exists for the same
// reason and has no effect with a single clock.

module fim_rdack_scfifo #(
    parameter int    DATA_WIDTH            = 1,
    parameter int    DEPTH_LOG2            = 6,
    parameter int    ALMOST_FULL_THRESHOLD = 2,
    parameter string READ_ACLR_SYNC        = "ON"
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    wreq,
    input  logic                    rdack,

    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [DEPTH_LOG2:0]     wusedw,
    output logic [DEPTH_LOG2:0]     rusedw,
    output logic                    wfull,
    output logic                    wempty,
    output logic                    almfull,
    output logic                    rempty,
    output logic                    rfull,
    output logic                    rvalid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Count-domain constants, sized to the occupancy counter.
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_LEVEL   = (DEPTH_LOG2+1)'(DEPTH - ALMOST_FULL_THRESHOLD);
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fim_rdack_scfifo: DATA_WIDTH must be >= 1");
    end
    if (DEPTH_LOG2 < 2) begin : g_bad_depth
        $error("fim_rdack_scfifo: DEPTH_LOG2 must be >= 2");
    end
    if ((ALMOST_FULL_THRESHOLD < 1) || (ALMOST_FULL_THRESHOLD > DEPTH - 1)) begin : g_bad_af
        $error("fim_rdack_scfifo: ALMOST_FULL_THRESHOLD out of range 1..2^DEPTH_LOG2-1");
    end
    if ((READ_ACLR_SYNC != "ON") && (READ_ACLR_SYNC != "OFF")) begin : g_bad_aclr
        $error("fim_rdack_scfifo: READ_ACLR_SYNC must be \"ON\" or \"OFF\"");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic [DEPTH_LOG2:0]    count_nxt;

    logic                   full_q;
    logic                   empty_q;
    logic                   almfull_q;

    logic                   write_en;
    logic                   read_en;

    // Acceptance is qualified by the registered flags, so a write into a full
    // FIFO is dropped even if a read frees a slot on the same edge, and a read
    // on an empty FIFO is dropped even if a write lands on the same edge.
    assign write_en = wreq  & ~full_q;
    assign read_en  = rdack & ~empty_q;

    always_comb begin
        count_nxt = count;
        case ({write_en, read_en})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and flags. Flags are computed from count_nxt so they
    // land in the same cycle as the count they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            almfull_q <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_nxt;
            full_q    <= (count_nxt == FULL_LEVEL);
            empty_q   <= (count_nxt == '0);
            almfull_q <= (count_nxt >= AF_LEVEL);
        end
    end

    // Storage array carries no reset; stale contents are never visible
    // because rvalid gates them.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Show-ahead read: head entry straight off the registered read pointer.
    assign rdata   = mem[rd_ptr];

    assign wusedw  = count;
    assign rusedw  = count;
    assign wfull   = full_q;
    assign rfull   = full_q;
    assign wempty  = empty_q;
    assign rempty  = empty_q;
    assign almfull = almfull_q;
    assign rvalid  = ~empty_q;

endmodule

// File: tb/tb_fim_rdack_scfifo.sv
module tb_fim_rdack_scfifo;

    localparam int DW    = 8;
    localparam int DL    = 2;
    localparam int AFT   = 1;
    localparam int DEPTH = 1 << DL;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wreq  = 1'b0;
    logic          rdack = 1'b0;

    logic [DW-1:0] rdata;
    logic [DL:0]   wusedw;
    logic [DL:0]   rusedw;
    logic          wfull;
    logic          wempty;
    logic          almfull;
    logic          rempty;
    logic          rfull;
    logic          rvalid;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue of the words currently held.
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    fim_rdack_scfifo #(
        .DATA_WIDTH            (DW),
        .DEPTH_LOG2            (DL),
        .ALMOST_FULL_THRESHOLD (AFT),
        .READ_ACLR_SYNC        ("ON")
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wdata   (wdata),
        .wreq    (wreq),
        .rdack   (rdack),
        .rdata   (rdata),
        .wusedw  (wusedw),
        .rusedw  (rusedw),
        .wfull   (wfull),
        .wempty  (wempty),
        .almfull (almfull),
        .rempty  (rempty),
        .rfull   (rfull),
        .rvalid  (rvalid)
    );

    // Drive one cycle of stimulus, update the model at the edge, and return
    // 1 time unit after the edge with the inputs idle.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        bit do_w;
        bit do_r;
        wreq  = w;
        wdata = d;
        rdack = r;
        @(posedge clk);
        do_w = w && (q.size() < DEPTH);
        do_r = r && (q.size() > 0);
        if (do_r) void'(q.pop_front());
        if (do_w) q.push_back(d);
        #1;
        wreq  = 1'b0;
        rdack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        checks++;
        if ({rvalid, rempty, wempty, wfull, rfull, almfull} !== 6'b011000) begin
            failures++;
            $display("FAIL reset_flags got rvalid/rempty/wempty/wfull/rfull/almfull=%b want 011000",
                     {rvalid, rempty, wempty, wfull, rfull, almfull});
        end
        checks++;
        if (wusedw !== '0 || rusedw !== '0) begin
            failures++;
            $display("FAIL reset_usedw got wusedw=%0d rusedw=%0d want 0", wusedw, rusedw);
        end
    endtask

    task automatic test_show_ahead();
        cycle(1'b1, 8'h0A, 1'b0);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h0A) begin
            failures++;
            $display("FAIL first_word got rvalid=%b rdata=%h want 1 0a", rvalid, rdata);
        end
        cycle(1'b1, 8'h0B, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (rdata !== 8'h0A || wusedw !== 3'd2) begin
            failures++;
            $display("FAIL hold_head got rdata=%h usedw=%0d want 0a 2", rdata, wusedw);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h0B) begin
            failures++;
            $display("FAIL second_word got rvalid=%b rdata=%h want 1 0b", rvalid, rdata);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b0 || rempty !== 1'b1 || wempty !== 1'b1) begin
            failures++;
            $display("FAIL drained got rvalid=%b rempty=%b wempty=%b want 0 1 1", rvalid, rempty, wempty);
        end
    endtask

    task automatic test_full_almfull();
        logic [DW-1:0] words[4];
        words = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 3; i++) cycle(1'b1, words[i], 1'b0);
        checks++;
        if (almfull !== 1'b1 || wfull !== 1'b0) begin
            failures++;
            $display("FAIL almfull_at_3 got almfull=%b wfull=%b want 1 0", almfull, wfull);
        end
        cycle(1'b1, words[3], 1'b0);
        checks++;
        if (wfull !== 1'b1 || rfull !== 1'b1 || wusedw !== 3'd4 || rusedw !== 3'd4) begin
            failures++;
            $display("FAIL full_at_4 got wfull=%b rfull=%b wusedw=%0d rusedw=%0d want 1 1 4 4",
                     wfull, rfull, wusedw, rusedw);
        end
        cycle(1'b1, 8'h0F, 1'b0);
        checks++;
        if (wusedw !== 3'd4 || wfull !== 1'b1) begin
            failures++;
            $display("FAIL drop_when_full got usedw=%0d wfull=%b want 4 1", wusedw, wfull);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== words[i]) begin
                failures++;
                $display("FAIL full_drain_%0d got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, words[i]);
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (rvalid !== 1'b0 || wusedw !== '0) begin
            failures++;
            $display("FAIL full_drain_end got rvalid=%b usedw=%0d want 0 0", rvalid, wusedw);
        end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
        cycle(1'b1, 8'h20, 1'b1);
        checks++;
        if (wusedw !== 3'd3 || wfull !== 1'b0) begin
            failures++;
            $display("FAIL full_wr_rd got usedw=%0d wfull=%b want 3 0", wusedw, wfull);
        end
        cycle(1'b1, 8'h21, 1'b0);
        checks++;
        if (wusedw !== 3'd4 || wfull !== 1'b1) begin
            failures++;
            $display("FAIL refill got usedw=%0d wfull=%b want 4 1", wusedw, wfull);
        end
        // Expected survivors: 0x11, 0x12, 0x13, 0x21 (0x20 was refused).
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] exp;
            exp = (i < 3) ? 8'h11 + 8'(i) : 8'h21;
            checks++;
            if (rdata !== exp) begin
                failures++;
                $display("FAIL simul_drain_%0d got rdata=%h want %h", i, rdata, exp);
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        // Empty FIFO with both requests: only the write happens.
        cycle(1'b1, 8'h33, 1'b1);
        checks++;
        if (wusedw !== 3'd1 || rvalid !== 1'b1 || rdata !== 8'h33) begin
            failures++;
            $display("FAIL empty_wr_rd got usedw=%0d rvalid=%b rdata=%h want 1 1 33", wusedw, rvalid, rdata);
        end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_streaming();
        logic [DW-1:0] seq_in[$];
        logic [DW-1:0] seq_out[$];
        int            bad_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 8'h40 + 8'(i), 1'b0);
            seq_in.push_back(8'h40 + 8'(i));
        end
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            seq_out.push_back(rdata);
            seq_in.push_back(8'h42 + 8'(i));
            cycle(1'b1, 8'h42 + 8'(i), 1'b1);
            if (wusedw !== 3'd2) bad_cnt++;
        end
        checks++;
        if (bad_cnt != 0) begin
            failures++;
            $display("FAIL stream_count got %0d cycles with usedw!=2 want 0", bad_cnt);
        end
        while (rvalid === 1'b1 && seq_out.size() < 40) begin
            seq_out.push_back(rdata);
            cycle(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (seq_out != seq_in) begin
            failures++;
            $display("FAIL stream_order got %0d words (first %h) want %0d words (first %h)",
                     seq_out.size(), seq_out[0], seq_in.size(), seq_in[0]);
        end
    endtask

    task automatic test_random();
        int flag_bad = 0;
        int data_bad = 0;
        for (int i = 0; i < 400; i++) begin
            logic [5:0] exp_flags;
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            exp_flags = {q.size() != 0, q.size() == 0, q.size() == 0,
                         q.size() == DEPTH, q.size() == DEPTH, q.size() >= DEPTH - AFT};
            if ({rvalid, rempty, wempty, wfull, rfull, almfull} !== exp_flags ||
                wusedw !== (DL+1)'(q.size()) || rusedw !== (DL+1)'(q.size())) begin
                if (flag_bad == 0)
                    $display("FAIL rand_status cycle %0d got flags=%b usedw=%0d/%0d want %b %0d",
                             i, {rvalid, rempty, wempty, wfull, rfull, almfull}, wusedw, rusedw,
                             exp_flags, q.size());
                flag_bad++;
            end
            if (q.size() > 0 && rdata !== q[0]) begin
                if (data_bad == 0)
                    $display("FAIL rand_data cycle %0d got rdata=%h want %h", i, rdata, q[0]);
                data_bad++;
            end
        end
        checks++;
        if (flag_bad != 0) failures++;
        checks++;
        if (data_bad != 0) failures++;
    endtask

    task automatic test_async_reset();
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if ({rvalid, rempty, wempty, wfull, rfull, almfull} !== 6'b011000 || wusedw !== '0) begin
            failures++;
            $display("FAIL async_reset got flags=%b usedw=%0d want 011000 0",
                     {rvalid, rempty, wempty, wfull, rfull, almfull}, wusedw);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h5A || wusedw !== 3'd1) begin
            failures++;
            $display("FAIL post_reset_write got rvalid=%b rdata=%h usedw=%0d want 1 5a 1",
                     rvalid, rdata, wusedw);
        end
    endtask

    initial begin
        test_reset();
        test_show_ahead();
        test_full_almfull();
        test_full_simultaneous();
        test_streaming();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
